// File: rtl/msi_req_sequencer.sv
// rtl/msi_req_sequencer.sv - trace-driven request sequencer; SEQ_LOOP_EN enables looped playback
module msi_req_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int PROC_W = 2,
    parameter int DEPTH  = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [IDX_W-1:0]  WrIdx,
    input  logic [1:0]        WrOp,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [PROC_W-1:0] WrProc,
    input  logic [DATA_W-1:0] WrData,
    input  logic [IDX_W:0]    Length,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Loop,
    output logic              ReqValid,
    input  logic              ReqReady,
    output logic [1:0]        ReqOp,
    output logic [ADDR_W-1:0] ReqAddr,
    output logic [PROC_W-1:0] ReqProc,
    output logic [DATA_W-1:0] ReqData,
    output logic              Busy,
    output logic              Done,
    output logic [15:0]       ReqCount
);
    localparam int ENT_W = 2 + ADDR_W + PROC_W + DATA_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] OP_GAP = 2'b10;
    localparam logic [1:0] OP_END = 2'b11;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W:0]    len_q, len_d;
    logic [DATA_W-1:0] gap_q, gap_d;
    logic [15:0]       count_q, count_d;

    logic [ENT_W-1:0]  cur_ent, look_ent;
    logic [IDX_W:0]    look_idx, look_len;
    logic              look, pass_end;

    // Trace memory is deliberately outside the reset domain so a restart replays it
    always_ff @(posedge Clock) begin
        if (WrEn && !Busy) begin
            mem_q[WrIdx] <= {WrOp, WrAddr, WrProc, WrData};
        end
    end

    assign cur_ent  = mem_q[idx_q];
    assign look_ent = mem_q[look_idx[IDX_W-1:0]];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        gap_d    = gap_q;
        count_d  = count_q;
        look     = 1'b0;
        pass_end = 1'b0;
        look_idx = {1'b0, idx_q} + 1'b1;
        look_len = len_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    count_d  = '0;
                    len_d    = Length;
                    look_idx = '0;
                    look_len = Length;
                    look     = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (ReqReady) begin
                    count_d = count_q + 16'd1;
                    look    = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q <= 1) look = 1'b1;
                else            gap_d = gap_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Resolve the next entry now so gap/end entries never cost an extra cycle
        if (look) begin
            if (look_idx >= look_len || look_idx[IDX_W] || look_ent[ENT_W-1 -: 2] == OP_END) begin
                pass_end = 1'b1;
            end else begin
                idx_d   = look_idx[IDX_W-1:0];
                state_d = (look_ent[ENT_W-1 -: 2] == OP_GAP) ? ST_GAP : ST_ISSUE;
                gap_d   = (look_ent[DATA_W-1:0] == '0) ? DATA_W'(1) : look_ent[DATA_W-1:0];
            end
        end

`ifdef SEQ_LOOP_EN
        if (pass_end && Loop && look_idx != '0 && mem_q[0][ENT_W-1 -: 2] != OP_END) begin
            pass_end = 1'b0;
            idx_d    = '0;
            state_d  = (mem_q[0][ENT_W-1 -: 2] == OP_GAP) ? ST_GAP : ST_ISSUE;
            gap_d    = (mem_q[0][DATA_W-1:0] == '0) ? DATA_W'(1) : mem_q[0][DATA_W-1:0];
        end
`else
        begin : loop_unused_blk
            logic unused_loop;
            unused_loop = Loop;
        end
`endif

        if (pass_end) begin
            state_d = ST_DONE;
            idx_d   = '0;
        end

        if (Abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            count_d = count_q;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            count_q <= count_d;
        end
    end

    assign ReqValid = (state_q == ST_ISSUE);
    assign Busy     = (state_q == ST_ISSUE) || (state_q == ST_GAP);
    assign Done     = (state_q == ST_DONE);
    assign ReqCount = count_q;
    assign ReqOp    = ReqValid ? cur_ent[ENT_W-1 -: 2]                 : '0;
    assign ReqAddr  = ReqValid ? cur_ent[DATA_W+PROC_W +: ADDR_W]      : '0;
    assign ReqProc  = ReqValid ? cur_ent[DATA_W +: PROC_W]             : '0;
    assign ReqData  = ReqValid ? cur_ent[DATA_W-1:0]                   : '0;
endmodule

// File: doc/msi_req_sequencer.md
MSI_REQ_SEQUENCER -- requirements
Module: msi_req_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, 4, request address code width.
REQ-002 SHALL have parameter DATA_W, 4, request data code width, also the gap length field.
REQ-003 SHALL have parameter PROC_W, 2, processor id width.
REQ-004 SHALL have parameter DEPTH, 16, trace entries, power of two >= 2; IDX_W = log2(DEPTH).
REQ-005 SHALL have port Clock  in  1  single clock, rising edge.
REQ-006 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port WrEn / WrIdx / WrOp / WrAddr / WrProc / WrData  in  1/IDX_W/2/ADDR_W/PROC_W/DATA_W  trace entry write.
REQ-008 SHALL have port Length  in  IDX_W+1  entries to play, sampled at Start.
REQ-009 SHALL have port Start  in  1  begin playback; Abort  in  1  stop immediately; Loop  in  1  repeat trace.
REQ-010 SHALL have port ReqValid  out  1; ReqReady  in  1; ReqOp  out  2; ReqAddr  out  ADDR_W; ReqProc  out  PROC_W; ReqData  out  DATA_W.
REQ-011 SHALL have port Busy  out  1; Done  out  1; ReqCount  out  16, accepted requests.

Function
REQ-012 Op codes SHALL be: 00 read, 01 write, 10 gap (idle DATA field cycles), 11 end marker.
REQ-013 FSM SHALL have states IDLE, ISSUE, GAP, DONE; Busy = ISSUE or GAP.
REQ-014 WrEn SHALL write the entry at WrIdx on the clock edge only in IDLE or DONE; ignored while Busy.
REQ-015 Start in IDLE/DONE with Length > 0 SHALL latch Length, clear index, ReqCount, Done, and enter ISSUE next cycle.
REQ-016 Start with Length = 0 SHALL go directly to DONE, with Done = 1 the next cycle and no request.
REQ-017 In ISSUE with a read or write entry, ReqValid SHALL be 1 and the Req* fields SHALL equal the entry at the current index.
REQ-018 Req* fields SHALL hold stable while ReqValid = 1 and ReqReady = 0.
REQ-019 A transfer (ReqValid and ReqReady at an edge) SHALL advance the index, increment ReqCount (wrapping at 2^16), and present the next entry the next cycle with no bubble.
REQ-020 A gap entry SHALL hold ReqValid = 0 for max(DATA,1) cycles in GAP, then advance the index.
REQ-021 An end-marker entry SHALL terminate the pass without issuing, as if the index reached Length.
REQ-022 Pass end (advance past Length-1, or end marker) SHALL enter DONE (Done = 1) unless looping per REQ-030.
REQ-023 Abort SHALL, at the next edge from any state, force IDLE, ReqValid = 0, Done = 0; ReqCount SHALL be kept; Abort SHALL take priority over Start and a simultaneous transfer (that transfer is not counted).
REQ-024 Start while Busy SHALL be ignored.
REQ-025 All outputs SHALL be registered or derived only from registered state and memory, with no combinational path from ReqReady to any output.

Reset
REQ-026 Reset SHALL asynchronously force IDLE, index 0, ReqValid 0, Busy 0, Done 0, ReqCount 0, and Req* 0.
REQ-027 Reset SHALL not clear trace memory contents.
REQ-028 Reset asserted mid-sequence SHALL drop ReqValid immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro SEQ_LOOP_EN SHALL control loop mode.
REQ-030 With SEQ_LOOP_EN defined and Loop = 1 at pass end, the index SHALL wrap to 0 and stay in ISSUE/GAP with no idle cycle and no Done.
REQ-031 Without SEQ_LOOP_EN, Loop SHALL be ignored and every pass end SHALL enter DONE.

Verification
REQ-032 Load entries {read P0 a1, read P0 a6, write P0 a6 d7, read P0 a5}, Length = 4, Start, ReqReady = 1 -> four back-to-back transfers with matching fields, then Done = 1 and ReqCount = 4.
REQ-033 Same trace with ReqReady low for 3 cycles on entry 2 -> ReqValid held and fields stable (op 01, addr 6, data 7); ReqCount = 4 at the end.
REQ-034 Entries {read a1, gap d3, write a5 d8}, Length = 3 -> ReqValid low exactly 3 cycles between the two transfers; ReqCount = 2.
REQ-035 End marker at entry 1 with Length = 4 -> one transfer, then Done; Length = 0 -> Done with no ReqValid.
REQ-036 Abort during entry 2 with ReqReady = 1 in the same cycle -> IDLE next cycle, ReqCount = 2; a separate run with Reset mid-run -> ReqValid drops immediately, and a restart replays the unchanged memory.
REQ-037 With SEQ_LOOP_EN defined, Loop = 1, Length = 2 -> entries 0,1,0,1... continuous with Done = 0; without the macro -> Done after 2 transfers.
